// File: rtl/line_fill_ctrl.sv
// Data-cache miss engine: optional dirty-line writeback, then a 16-byte line read.
// Memory enables are gated by mem_ready; a watchdog aborts stalled transfers.
module line_fill_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic         req_evict,
  input  logic [31:0]  req_evict_addr,
  input  logic [127:0] req_evict_data,
  output logic         fill_valid,
  output logic [31:0]  fill_addr,
  output logic [127:0] fill_data,
  output logic         err,
  output logic         busy,
  output logic         mem_read_en,
  output logic         mem_write_en,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_write_data,
  input  logic [127:0] mem_read_data,
  input  logic         mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    WB,
    RD,
    RESP
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t       state;
  logic [7:0]   wait_cnt;
  logic [31:0]  line_addr;
  logic [31:0]  victim_addr;
  logic [127:0] victim_data;
  logic         at_limit;
  logic         expire;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[3:0], req_evict_addr[3:0]};

  assign at_limit = (wait_cnt == WAIT_LAST);
  assign expire   = at_limit && !mem_ready;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Enables must already be low in the ready cycle and the timeout cycle.
  assign mem_write_en = (state == WB) && !mem_ready && !at_limit;
  assign mem_read_en  = (state == RD) && !mem_ready && !at_limit;

  assign mem_addr = (state == WB) ? victim_addr :
                    (state == RD) ? line_addr   : '0;
  assign mem_write_data = (state == WB) ? victim_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      line_addr   <= '0;
      victim_addr <= '0;
      victim_data <= '0;
      fill_valid  <= 1'b0;
      fill_addr   <= '0;
      fill_data   <= '0;
      err         <= 1'b0;
    end else begin
      fill_valid <= 1'b0;
      err        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            line_addr   <= {req_addr[31:4], 4'b0};
            victim_addr <= {req_evict_addr[31:4], 4'b0};
            victim_data <= req_evict_data;
            wait_cnt    <= '0;
            state       <= req_evict ? WB : RD;
          end
        end
        WB: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            state    <= RD;
          end else if (expire) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RD: begin
          if (mem_ready) begin
            fill_data  <= mem_read_data;
            fill_addr  <= line_addr;
            fill_valid <= 1'b1;
            state      <= RESP;
          end else if (expire) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
